// File: rtl/fp_pkg.sv
// fp_pkg: shared state encoding, default formats and IEEE-style bit-pattern helpers for the chain multiplier.
package fp_pkg;

    typedef enum logic [2:0] {IDLE, CLASSIFY, MUL, PACK, DONE} state_t;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] fp_zero(input int exp_w, input int man_w, input logic sign);
        return 64'(sign) << (exp_w + man_w);
    endfunction

    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w, input logic sign);
        return fp_zero(exp_w, man_w, sign) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

    // Canonical quiet NaN: positive, exponent all ones, only the mantissa MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w, 1'b0) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_mul_step.sv
// fp_mul_step: one combinational multiply step on unpacked normal operands with RNE rounding and range flags.
module fp_mul_step
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic signed [EXP_W+1:0] acc_exp_i,
    input  logic [MAN_W-1:0]        acc_man_i,
    input  logic [EXP_W-1:0]        op_exp_i,
    input  logic [MAN_W-1:0]        op_man_i,
    output logic signed [EXP_W+1:0] exp_o,
    output logic [MAN_W-1:0]        man_o,
    output logic                    ovf_o,
    output logic                    unf_o
);

    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * (MAN_W + 1);
    localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 2);

    logic [PW-1:0]          prod;
    logic [MAN_W:0]         kept;
    logic                   norm, guard, sticky, rnd_up, carry;
    logic signed [EW-1:0]   op_e, inc;

    assign prod   = {1'b1, acc_man_i} * {1'b1, op_man_i};
    assign norm   = prod[PW-1];
    assign kept   = norm ? prod[PW-1:MAN_W+1] : prod[PW-2:MAN_W];
    assign guard  = norm ? prod[MAN_W] : prod[MAN_W-1];
    assign sticky = norm ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
    assign rnd_up = guard & (sticky | kept[0]);
    // Rounding an all-ones significand carries out; the stored mantissa wraps to zero and the exponent absorbs it.
    assign carry  = rnd_up & (&kept);
    assign man_o  = kept[MAN_W-1:0] + MAN_W'(rnd_up);
    assign op_e   = {2'b00, op_exp_i};
    assign inc    = EW'(norm) + EW'(carry);
    assign exp_o  = acc_exp_i + op_e - BIAS + inc;
    assign ovf_o  = exp_o > EMAX;
    assign unf_o  = exp_o <= 0;

endmodule

// File: rtl/fp_chain_multiplier.sv
// fp_chain_multiplier: multiplies NUM_OPS floating-point operands left to right with rounding after every step.
module fp_chain_multiplier
    import fp_pkg::*;
#(
    parameter int NUM_OPS = 3,
    parameter int EXP_W   = DEF_EXP_W,
    parameter int MAN_W   = DEF_MAN_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NUM_OPS*(1+EXP_W+MAN_W)-1:0]  input_ops,
    output logic                                ready,
    output logic [EXP_W+MAN_W:0]                output_z,
    output logic                                z_ack,
    output logic                                overflow,
    output logic                                underflow,
    output logic                                invalid
);

    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int IW = $clog2(NUM_OPS);
    localparam logic [IW-1:0] LAST  = IW'(NUM_OPS - 1);
    localparam logic [FW-1:0] QNAN   = FW'(fp_qnan(EXP_W, MAN_W));
    localparam logic [FW-1:0] INF_P  = FW'(fp_inf(EXP_W, MAN_W, 1'b0));
    localparam logic [FW-1:0] INF_N  = FW'(fp_inf(EXP_W, MAN_W, 1'b1));
    localparam logic [FW-1:0] ZERO_P = FW'(fp_zero(EXP_W, MAN_W, 1'b0));
    localparam logic [FW-1:0] ZERO_N = FW'(fp_zero(EXP_W, MAN_W, 1'b1));

    state_t                 state_q, state_d;
    logic [NUM_OPS*FW-1:0]  ops_q;
    logic [IW-1:0]          idx_q;
    logic signed [EW-1:0]   acc_exp_q, step_exp;
    logic [MAN_W-1:0]       acc_man_q, step_man;
    logic                   sign_q, zero_q, inf_q, nan_q, ovf_q, unf_q, inv_q;
    logic [FW-1:0]          res_q, z_q, cur, pack_d;
    logic                   z_ack_q, ovf_out_q, unf_out_q, inv_out_q;
    logic                   c_sign, c_zero, c_inf, c_nan;
    logic                   step_ovf, step_unf, halt, accept, pack_inv;

    // The IDLE cycle that still shows z_ack is not ready, so a new request lands one cycle later.
    assign ready     = (state_q == IDLE) & ~z_ack_q;
    assign accept    = ready & start;
    assign output_z  = z_q;
    assign z_ack     = z_ack_q;
    assign overflow  = ovf_out_q;
    assign underflow = unf_out_q;
    assign invalid   = inv_out_q;

    always_comb begin
        c_sign = 1'b0;
        c_zero = 1'b0;
        c_inf  = 1'b0;
        c_nan  = 1'b0;
        cur    = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            cur    = ops_q[k*FW +: FW];
            c_sign = c_sign ^ cur[FW-1];
            c_zero = c_zero | (cur[FW-2:MAN_W] == '0);
            c_inf  = c_inf | ((&cur[FW-2:MAN_W]) & (cur[MAN_W-1:0] == '0));
            c_nan  = c_nan | ((&cur[FW-2:MAN_W]) & (cur[MAN_W-1:0] != '0));
        end
    end

    fp_mul_step #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_step (
        .acc_exp_i (acc_exp_q),
        .acc_man_i (acc_man_q),
        .op_exp_i  (ops_q[int'(idx_q)*FW+MAN_W +: EXP_W]),
        .op_man_i  (ops_q[int'(idx_q)*FW +: MAN_W]),
        .exp_o     (step_exp),
        .man_o     (step_man),
        .ovf_o     (step_ovf),
        .unf_o     (step_unf)
    );

    // Once a special operand is seen or the range is exceeded the accumulator is frozen; PACK decides the result.
    assign halt     = zero_q | inf_q | nan_q | ovf_q | unf_q;
    assign pack_inv = nan_q | (inf_q & zero_q);
    assign pack_d   = pack_inv         ? QNAN :
                      (inf_q | ovf_q)  ? (sign_q ? INF_N : INF_P) :
                      (zero_q | unf_q) ? (sign_q ? ZERO_N : ZERO_P) :
                                         {sign_q, acc_exp_q[EXP_W-1:0], acc_man_q};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     state_d = accept ? CLASSIFY : IDLE;
            CLASSIFY: state_d = MUL;
            MUL:      state_d = (idx_q == LAST) ? PACK : MUL;
            PACK:     state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q     <= '0;
            idx_q     <= '0;
            acc_exp_q <= '0;
            acc_man_q <= '0;
            {sign_q, zero_q, inf_q, nan_q, ovf_q, unf_q, inv_q} <= '0;
            res_q     <= '0;
            z_q       <= '0;
            z_ack_q   <= 1'b0;
            {ovf_out_q, unf_out_q, inv_out_q} <= '0;
        end else begin
            z_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        ops_q <= input_ops;
                        {ovf_q, unf_q, inv_q} <= '0;
                    end
                end
                CLASSIFY: begin
                    acc_exp_q <= {2'b00, ops_q[FW-2:MAN_W]};
                    acc_man_q <= ops_q[MAN_W-1:0];
                    {sign_q, zero_q, inf_q, nan_q} <= {c_sign, c_zero, c_inf, c_nan};
                    idx_q     <= IW'(1);
                end
                MUL: begin
                    idx_q <= idx_q + 1'b1;
                    if (!halt) begin
                        if (step_ovf) begin
                            ovf_q     <= 1'b1;
                            acc_exp_q <= {2'b00, {EXP_W{1'b1}}};
                            acc_man_q <= '0;
                        end else if (step_unf) begin
                            unf_q     <= 1'b1;
                            acc_exp_q <= '0;
                            acc_man_q <= '0;
                        end else begin
                            acc_exp_q <= step_exp;
                            acc_man_q <= step_man;
                        end
                    end
                end
                PACK: begin
                    res_q <= pack_d;
                    inv_q <= pack_inv;
                end
                DONE: begin
                    z_q       <= res_q;
                    z_ack_q   <= 1'b1;
                    ovf_out_q <= ovf_q;
                    unf_out_q <= unf_q;
                    inv_out_q <= inv_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_chain_multiplier.sv
// tb_fp_chain_multiplier: directed and random checks of the chain multiplier against an integer-arithmetic reference.
module tb_fp_chain_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         start = 1'b0, start2 = 1'b0, start8 = 1'b0;
    logic [95:0]  ops = '0;
    logic [63:0]  ops2 = '0;
    logic [255:0] ops8 = '0;
    logic         ready, z_ack, overflow, underflow, invalid;
    logic         ready2, z_ack2, overflow2, underflow2, invalid2;
    logic         ready8, z_ack8, overflow8, underflow8, invalid8;
    logic [31:0]  output_z, output_z2, output_z8;
    int           errors = 0, checks = 0;

    fp_chain_multiplier #(.NUM_OPS(3)) dut (
        .clk(clk), .reset(reset), .start(start), .input_ops(ops), .ready(ready), .output_z(output_z),
        .z_ack(z_ack), .overflow(overflow), .underflow(underflow), .invalid(invalid));

    fp_chain_multiplier #(.NUM_OPS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .input_ops(ops2), .ready(ready2), .output_z(output_z2),
        .z_ack(z_ack2), .overflow(overflow2), .underflow(underflow2), .invalid(invalid2));

    fp_chain_multiplier #(.NUM_OPS(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .input_ops(ops8), .ready(ready8), .output_z(output_z8),
        .z_ack(z_ack8), .overflow(overflow8), .underflow(underflow8), .invalid(invalid8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product rounded by comparing the discarded part with one half.
    function automatic void ref_mul(input logic [31:0] op [8], input int n,
                                    output logic [31:0] z, output logic o, output logic u, output logic inv);
        logic s = 1'b0, zr = 1'b0, nf = 1'b0, nn = 1'b0;
        longint ma, mb, p, q, r, h;
        int ea, eb, e, sh;
        o = 1'b0;
        u = 1'b0;
        for (int k = 0; k < n; k++) begin
            s  = s ^ op[k][31];
            zr = zr | (op[k][30:23] == 8'd0);
            nf = nf | (op[k][30:23] == 8'hFF && op[k][22:0] == 23'd0);
            nn = nn | (op[k][30:23] == 8'hFF && op[k][22:0] != 23'd0);
        end
        ma = longint'({1'b1, op[0][22:0]});
        ea = int'(op[0][30:23]);
        if (!(zr || nf || nn)) begin
            for (int k = 1; k < n && !o && !u; k++) begin
                mb = longint'({1'b1, op[k][22:0]});
                eb = int'(op[k][30:23]);
                p  = ma * mb;
                sh = (p >= (longint'(1) << 47)) ? 24 : 23;
                e  = ea + eb - 127 + (sh - 23);
                q  = p >> sh;
                r  = p - (q << sh);
                h  = longint'(1) << (sh - 1);
                if (r > h || (r == h && q[0])) q++;
                if (q == (longint'(1) << 24)) begin
                    q = longint'(1) << 23;
                    e++;
                end
                if (e > 254) o = 1'b1;
                else if (e < 1) u = 1'b1;
                else begin
                    ma = q;
                    ea = e;
                end
            end
        end
        inv = nn || (nf && zr);
        if (inv) z = 32'h7FC00000;
        else if (nf || o) z = {s, 8'hFF, 23'd0};
        else if (zr || u) z = {s, 31'd0};
        else z = {s, 8'(ea), 23'(ma)};
    endfunction

    function automatic logic [31:0] rnd_op();
        int         r = int'($urandom_range(0, 99));
        logic [7:0] e = 8'($urandom_range(110, 144));
        logic [22:0] m = 23'($urandom);
        if (r < 5) e = 8'd0;
        else if (r < 8) begin e = 8'hFF; m = 23'd0; end
        else if (r < 10) begin e = 8'hFF; m = m | 23'd1; end
        else if (r < 25) e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, m};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a [8], input bit hold,
                          input logic [31:0] ez, input logic eo, input logic eu, input logic ei);
        int cyc = 0;
        int acks = 0;
        check({tag, " ready_before"}, 64'(ready), 64'd1);
        ops   = {a[2], a[1], a[0]};
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = hold;
        ops   = {$urandom, $urandom, $urandom};
        while (!z_ack && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd5);
        check({tag, " z"}, 64'(output_z), 64'(ez));
        check({tag, " flags"}, 64'({overflow, underflow, invalid}), 64'({eo, eu, ei}));
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " ready_after"}, 64'(ready), 64'd1);
        check({tag, " z_held"}, 64'(output_z), 64'(ez));
        if (hold) begin
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                @(negedge clk);
                acks += int'(z_ack);
            end
            check({tag, " extra_ack"}, 64'(acks), 64'd0);
        end
    endtask

    task automatic run3(input string tag, input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                        input bit hold, input logic [31:0] ez, input logic eo, input logic eu, input logic ei);
        logic [31:0] a [8];
        foreach (a[k]) a[k] = 32'h3F800000;
        a[0] = x0;
        a[1] = x1;
        a[2] = x2;
        run_op(tag, a, hold, ez, eo, eu, ei);
    endtask

    initial begin
        logic [31:0] a [8];
        logic [31:0] ez;
        logic eo, eu, ei;
        int cyc, acks, lat2, lat8;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", 64'(ready), 64'd1);
        check("rst z_ack", 64'(z_ack), 64'd0);
        check("rst z", 64'(output_z), 64'd0);
        check("rst flags", 64'({overflow, underflow, invalid}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run3("mul_2x3x05", 32'h40000000, 32'h40400000, 32'h3F000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0);
        run3("round_rne",  32'h3F800001, 32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800003, 1'b0, 1'b0, 1'b0);
        run3("neg_zero",   32'h80000000, 32'h40000000, 32'h3F800000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0);
        run3("underflow",  32'h00800000, 32'h3F000000, 32'h3F800000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0);
        run3("overflow",   32'h7F000000, 32'h7F000000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0);
        run3("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
        run3("tie_even",   32'h3FC00000, 32'h3F800001, 32'h3F800000, 1'b0, 32'h3FC00002, 1'b0, 1'b0, 1'b0);
        run3("start_held", 32'h40000000, 32'h40400000, 32'h3F000000, 1'b1, 32'h40400000, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            foreach (a[k]) a[k] = rnd_op();
            ref_mul(a, 3, ez, eo, eu, ei);
            run_op($sformatf("rand%0d", t), a, 1'b0, ez, eo, eu, ei);
        end

        ops   = {32'h3F800000, 32'h40400000, 32'h40000000};
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("abort ready", 64'(ready), 64'd1);
        check("abort z", 64'(output_z), 64'd0);
        check("abort flags", 64'({z_ack, overflow, underflow, invalid}), 64'd0);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            acks += int'(z_ack);
        end
        check("abort no_ack", 64'(acks), 64'd0);
        run3("post_abort", 32'h40000000, 32'h40400000, 32'h3F000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0);

        ops2   = {2{32'h3F800000}};
        ops8   = {8{32'h3F800000}};
        start2 = 1'b1;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        start8 = 1'b0;
        lat2 = -1;
        lat8 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (z_ack2 && lat2 < 0) lat2 = c;
            if (z_ack8 && lat8 < 0) lat8 = c;
        end
        check("n2 latency", 64'(lat2), 64'd4);
        check("n2 z", 64'(output_z2), 64'h3F800000);
        check("n2 flags", 64'({overflow2, underflow2, invalid2}), 64'd0);
        check("n8 latency", 64'(lat8), 64'd10);
        check("n8 z", 64'(output_z8), 64'h3F800000);
        check("n8 flags", 64'({overflow8, underflow8, invalid8}), 64'd0);

        for (int t = 0; t < 20; t++) begin
            foreach (a[k]) a[k] = rnd_op();
            ref_mul(a, 8, ez, eo, eu, ei);
            for (int k = 0; k < 8; k++) ops8[k*32 +: 32] = a[k];
            check($sformatf("n8_rand%0d ready", t), 64'(ready8), 64'd1);
            start8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start8 = 1'b0;
            cyc = 0;
            while (!z_ack8 && cyc < 30) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
            check($sformatf("n8_rand%0d latency", t), 64'(cyc), 64'd10);
            check($sformatf("n8_rand%0d z", t), 64'(output_z8), 64'(ez));
            check($sformatf("n8_rand%0d flags", t), 64'({overflow8, underflow8, invalid8}), 64'({eo, eu, ei}));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
